// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Two-channel (key/button) switch debouncer with press/release
//            pulses; optional long-press pulse under KEY_DEBOUNCE_LONGPRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEB_CYCLES  = 20,
    parameter int LONG_CYCLES = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    input  logic button,
    output logic key_level,
    output logic button_level,
    output logic key_press,
    output logic button_press,
    output logic key_release,
    output logic button_release,
    output logic key_long,
    output logic button_long
);

    localparam int                 c_CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_DN_WAIT = 2'd1,
        ST_DOWN    = 2'd2,
        ST_UP_WAIT = 2'd3
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] r_meta;
    logic [1:0] r_sync;
    logic [1:0] w_level;
    logic [1:0] w_press;
    logic [1:0] w_release;
    logic [1:0] w_long;

    assign w_raw = {button, key};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_chan
        state_t             r_state;
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_level;
        logic               r_press;
        logic               r_release;

        // cnt is cleared on every state entry so it never has to wrap.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= ST_UP;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                case (r_state)
                    ST_UP: begin
                        if (r_sync[g]) begin
                            r_state <= ST_DN_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_DN_WAIT: begin
                        if (!r_sync[g]) begin
                            r_state <= ST_UP;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_state <= ST_DOWN;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    ST_DOWN: begin
                        if (!r_sync[g]) begin
                            r_state <= ST_UP_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                    ST_UP_WAIT: begin
                        if (r_sync[g]) begin
                            r_state <= ST_DOWN;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_state   <= ST_UP;
                            r_cnt     <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_UP;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_level[g]   = r_level;
        assign w_press[g]   = r_press;
        assign w_release[g] = r_release;

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        localparam int                  c_HOLD_W    = $clog2(LONG_CYCLES + 1);
        localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES);
        localparam logic [c_HOLD_W-1:0] c_HOLD_PRE  = c_HOLD_W'(LONG_CYCLES - 1);
        localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

        logic [c_HOLD_W-1:0] r_hold;
        logic                r_long;

        // Saturating at LONG_CYCLES guarantees a single long pulse per press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else begin
                r_long <= 1'b0;
                if (r_state == ST_UP) begin
                    r_hold <= '0;
                end else if (r_state == ST_DOWN && r_hold != c_HOLD_LAST) begin
                    r_hold <= r_hold + c_HOLD_ONE;
                    r_long <= (r_hold == c_HOLD_PRE);
                end
            end
        end

        assign w_long[g] = r_long;
`else
        assign w_long[g] = 1'b0;
`endif
    end

    assign key_level      = w_level[0];
    assign button_level   = w_level[1];
    assign key_press      = w_press[0];
    assign button_press   = w_press[1];
    assign key_release    = w_release[0];
    assign button_release = w_release[1];
    assign key_long       = w_long[0];
    assign button_long    = w_long[1];

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce
// Brief    : Directed self-checking bench for key_debounce (DEB=4, LONG=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    logic clk;
    logic rst_n;
    logic key;
    logic button;
    logic key_level;
    logic button_level;
    logic key_press;
    logic button_press;
    logic key_release;
    logic button_release;
    logic key_long;
    logic button_long;

    int errors = 0;
    int checks = 0;

    // Observation counters; "first" is the edge index (0 = first edge
    // after the stimulus change) at which the pulse was seen.
    int kp_cnt, kp_first, kr_cnt, kr_first, kl_cnt, kl_first;
    int bp_cnt, bp_first, br_cnt, br_first, bl_cnt;
    int lvl_seen;

    key_debounce #(
        .DEB_CYCLES (4),
        .LONG_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key           (key),
        .button        (button),
        .key_level     (key_level),
        .button_level  (button_level),
        .key_press     (key_press),
        .button_press  (button_press),
        .key_release   (key_release),
        .button_release(button_release),
        .key_long      (key_long),
        .button_long   (button_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {key_level, button_level, key_press, button_press,
                key_release, button_release, key_long, button_long};
    endfunction

    task automatic clear_obs();
        kp_cnt = 0; kp_first = -1; kr_cnt = 0; kr_first = -1;
        kl_cnt = 0; kl_first = -1; bp_cnt = 0; bp_first = -1;
        br_cnt = 0; br_first = -1; bl_cnt = 0; lvl_seen = 0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (key_press)      begin kp_cnt++; if (kp_first < 0) kp_first = i; end
            if (key_release)    begin kr_cnt++; if (kr_first < 0) kr_first = i; end
            if (key_long)       begin kl_cnt++; if (kl_first < 0) kl_first = i; end
            if (button_press)   begin bp_cnt++; if (bp_first < 0) bp_first = i; end
            if (button_release) begin br_cnt++; if (br_first < 0) br_first = i; end
            if (button_long)    bl_cnt++;
            if (key_level)      lvl_seen = 1;
        end
    endtask

    task automatic test_reset();
        int nz;
        nz = 0;
        #3;
        checks++;
        if (outs() !== 8'h00) begin
            errors++; $display("FAIL reset_async: outs=%b expected 00000000", outs());
        end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (outs() !== 8'h00) nz = 1;
        end
        checks++;
        if (nz !== 0) begin
            errors++; $display("FAIL reset_hold: nonzero output seen=%0d expected 0", nz);
        end
        rst_n = 1'b1;
        clear_obs();
        watch(12);
        checks++;
        if (kp_first !== 6) begin
            errors++; $display("FAIL reset_press_edge: got %0d expected 6", kp_first);
        end
        checks++;
        if (kp_cnt !== 1) begin
            errors++; $display("FAIL reset_press_count: got %0d expected 1", kp_cnt);
        end
        checks++;
        if (key_level !== 1'b1 || bp_cnt !== 0) begin
            errors++; $display("FAIL reset_level: key_level=%b bp_cnt=%0d expected 1/0", key_level, bp_cnt);
        end
        key = 1'b0;
        clear_obs();
        watch(12);
        checks++;
        if (kr_first !== 6 || kr_cnt !== 1 || key_level !== 1'b0) begin
            errors++; $display("FAIL release_timing: edge=%0d cnt=%0d level=%b expected 6/1/0", kr_first, kr_cnt, key_level);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        for (int r = 0; r < 5; r++) begin
            key = 1'b1;
            watch(3);
            key = 1'b0;
            watch(3);
        end
        watch(10);
        checks++;
        if (kp_cnt !== 0) begin
            errors++; $display("FAIL glitch_press: got %0d expected 0", kp_cnt);
        end
        checks++;
        if (kr_cnt !== 0) begin
            errors++; $display("FAIL glitch_release: got %0d expected 0", kr_cnt);
        end
        checks++;
        if (lvl_seen !== 0) begin
            errors++; $display("FAIL glitch_level: seen=%0d expected 0", lvl_seen);
        end
    endtask

    task automatic test_bounce_release();
        key = 1'b1;
        clear_obs();
        watch(12);
        checks++;
        if (kp_cnt !== 1 || key_level !== 1'b1) begin
            errors++; $display("FAIL bounce_setup: cnt=%0d level=%b expected 1/1", kp_cnt, key_level);
        end
        clear_obs();
        for (int r = 0; r < 2; r++) begin
            key = 1'b0;
            watch(2);
            key = 1'b1;
            watch(2);
        end
        checks++;
        if (kr_cnt !== 0 || kp_cnt !== 0 || key_level !== 1'b1) begin
            errors++; $display("FAIL bounce_mid: rel=%0d press=%0d level=%b expected 0/0/1", kr_cnt, kp_cnt, key_level);
        end
        key = 1'b0;
        clear_obs();
        watch(14);
        checks++;
        if (kr_first !== 6) begin
            errors++; $display("FAIL bounce_release_edge: got %0d expected 6", kr_first);
        end
        checks++;
        if (kr_cnt !== 1 || kp_cnt !== 0) begin
            errors++; $display("FAIL bounce_counts: rel=%0d press=%0d expected 1/0", kr_cnt, kp_cnt);
        end
    endtask

    task automatic test_simultaneous();
        key = 1'b1;
        button = 1'b1;
        clear_obs();
        watch(12);
        checks++;
        if (kp_first !== 6 || bp_first !== 6) begin
            errors++; $display("FAIL simul_press: key=%0d button=%0d expected 6/6", kp_first, bp_first);
        end
        checks++;
        if (button_level !== 1'b1 || bp_cnt !== 1) begin
            errors++; $display("FAIL simul_button_level: level=%b cnt=%0d expected 1/1", button_level, bp_cnt);
        end
        key = 1'b0;
        button = 1'b0;
        clear_obs();
        watch(12);
        checks++;
        if (kr_first !== 6 || br_first !== 6) begin
            errors++; $display("FAIL simul_release: key=%0d button=%0d expected 6/6", kr_first, br_first);
        end
    endtask

    task automatic test_long();
        key = 1'b1;
        clear_obs();
        watch(40);
        checks++;
        if (kp_first !== 6) begin
            errors++; $display("FAIL long_press_edge: got %0d expected 6", kp_first);
        end
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
        checks++;
        if (kl_cnt !== 1 || kl_first !== 22) begin
            errors++; $display("FAIL long_pulse: cnt=%0d edge=%0d expected 1/22", kl_cnt, kl_first);
        end
`else
        checks++;
        if (kl_cnt !== 0) begin
            errors++; $display("FAIL long_disabled: cnt=%0d expected 0", kl_cnt);
        end
`endif
        checks++;
        if (bl_cnt !== 0) begin
            errors++; $display("FAIL long_button: cnt=%0d expected 0", bl_cnt);
        end
        key = 1'b0;
        watch(12);
    endtask

    task automatic test_reset_mid();
        key = 1'b1;
        clear_obs();
        watch(12);
        checks++;
        if (key_level !== 1'b1) begin
            errors++; $display("FAIL rstmid_setup: level=%b expected 1", key_level);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (key_level !== 1'b0 || key_release !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: level=%b rel=%b expected 0/0", key_level, key_release);
        end
        clear_obs();
        watch(3);
        rst_n = 1'b1;
        watch(0);
        clear_obs();
        watch(12);
        checks++;
        if (kp_first !== 6 || kp_cnt !== 1) begin
            errors++; $display("FAIL rstmid_repress: edge=%0d cnt=%0d expected 6/1", kp_first, kp_cnt);
        end
        checks++;
        if (kr_cnt !== 0 || kl_cnt !== 0) begin
            errors++; $display("FAIL rstmid_no_release: rel=%0d long=%0d expected 0/0", kr_cnt, kl_cnt);
        end
        key = 1'b0;
        watch(12);
    endtask

    initial begin
        rst_n  = 1'b0;
        key    = 1'b1;
        button = 1'b0;
        clear_obs();
        test_reset();
        test_glitch();
        test_bounce_release();
        test_simultaneous();
        test_long();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 20, giving the stable-sample count that qualifies a level change (legal range 2..65535).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 100, giving the held-down cycles that qualify a long press (legal range 2..65535, used only under REQ-021).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-005 The block SHALL have ports key and button, inputs, 1 bit each: raw asynchronous switches, where 1 means pressed.
REQ-006 The block SHALL have ports key_level and button_level, outputs, 1 bit each: the debounced switch states.
REQ-007 The block SHALL have ports key_press and button_press, outputs, 1 bit each: one-cycle pulses on a debounced 0->1 change.
REQ-008 The block SHALL have ports key_release and button_release, outputs, 1 bit each: one-cycle pulses on a debounced 1->0 change.
REQ-009 The block SHALL have ports key_long and button_long, outputs, 1 bit each: one-cycle long-press pulses.

Function
REQ-010 Each raw input SHALL pass through a two-flop synchronizer (reset value 0); only the second flop output (sync) feeds the channel logic.
REQ-011 The key and button channels SHALL be identical and fully independent; simultaneous events on both channels SHALL each produce their own pulses in the same cycle.
REQ-012 Each channel SHALL implement an FSM with four states: UP, DN_WAIT, DOWN and UP_WAIT.
REQ-013 In UP, sync=1 SHALL move the FSM to DN_WAIT with cnt=0; sync=0 SHALL keep it in UP.
REQ-014 In DN_WAIT, sync=0 SHALL return the FSM to UP (glitch rejected, no pulse); sync=1 with cnt=DEB_CYCLES-1 SHALL move it to DOWN, set level=1 and pulse press; otherwise cnt SHALL increment.
REQ-015 In DOWN, sync=0 SHALL move the FSM to UP_WAIT with cnt=0.
REQ-016 In UP_WAIT, sync=1 SHALL return the FSM to DOWN with no press pulse; sync=0 with cnt=DEB_CYCLES-1 SHALL move it to UP, set level=0 and pulse release; otherwise cnt SHALL increment.
REQ-017 All outputs SHALL be registered, and each pulse SHALL last exactly one cycle.
REQ-018 Latency: if a raw input rises before edge E0 and stays stable, press SHALL be high during the cycle following edge E0+DEB_CYCLES+2; release timing SHALL be symmetric.
REQ-019 cnt SHALL be sized to hold DEB_CYCLES-1 and SHALL never wrap; it is only compared for equality and cleared on every state entry.
REQ-020 When debounced, level SHALL equal 1 in DOWN and UP_WAIT, and 0 in UP and DN_WAIT.

Configuration
REQ-021 With macro KEY_DEBOUNCE_LONGPRESS_EN defined, each channel SHALL count cycles spent in DOWN using a hold counter that pauses in UP_WAIT, clears on entering UP, and saturates; when the count reaches LONG_CYCLES, long SHALL pulse once per press.
REQ-022 Without KEY_DEBOUNCE_LONGPRESS_EN, key_long and button_long SHALL be tied to 0, and no hold counter logic SHALL be synthesized; the port list SHALL be unchanged.

Reset
REQ-023 When rst_n=0, regardless of clk, the block SHALL asynchronously clear synchronizers, FSMs (to UP), cnt and hold counters, and drive all outputs to 0.
REQ-024 Reset asserted mid-operation (any state) SHALL produce no release or long pulse; after deassertion, a still-pressed input SHALL be re-qualified from UP per REQ-018.

Verification (DEB_CYCLES=4, LONG_CYCLES=16)
REQ-025 Bench: rst_n=0 with key=1 for 50 cycles -> all outputs 0; then rst_n=1 with key held -> key_press high for one cycle at edge 6 after release, key_level=1 thereafter.
REQ-026 Bench: key=1 for 3 cycles then 0, repeated 5 times -> key_press, key_release and key_level stay 0.
REQ-027 Bench: key pressed and stable, then release with 2-cycle bounces (0,1,0,0...) -> exactly one key_release, 6 edges after the last 1->0, and no extra key_press.
REQ-028 Bench: key and button rise on the same edge -> key_press and button_press pulse in the same cycle.
REQ-029 Bench: key held 40 cycles -> with macro, one key_long pulse 16 cycles after key_press; without macro, key_long stays 0.
REQ-030 Bench: rst_n pulsed low while key_level=1 -> key_level drops to 0 immediately with no key_release, and key_press recurs 6 edges after rst_n returns high.
